nn_infer_ctrl: RTL

Synthesizable initiator for the HLS inference core's ap_ctrl_hs interface (ap_start/ap_done/ap_idle/ap_ready, ap_vld data ports). It accepts input feature vectors on a valid/ready stream, buffers them in a small FIFO, and issues one inference at a time to the core. It captures the core's ap_vld-qualified result and returns it on a valid/ready result stream with an error flag. It sits between the host/DMA data path and the generated core, replacing bench-only stimulus with real sequencing.

---
 rtl/nn_infer_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/nn_infer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nn_infer_ctrl
//  Purpose  : Initiator for an HLS inference core with an ap_ctrl_hs handshake.
//             Input vectors are buffered in a small FIFO and issued to the core
//             one at a time. The ap_vld-qualified result comes back on a
//             valid/ready stream, together with an error flag for timeouts and
//             for results that never arrived.
//  Revision : 1.0  initial release
// ============================================================================
module nn_infer_ctrl #(
    parameter int IN_W       = 48,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_err,
    output logic             core_start,
    output logic [IN_W-1:0]  core_in,
    output logic             core_in_vld,
    input  logic             core_done,
    input  logic             core_idle,
    input  logic             core_ready,
    input  logic [OUT_W-1:0] core_out,
    input  logic             core_out_vld,
    output logic             busy,
    output logic [15:0]      infer_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_live;
    logic [IN_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [TW-1:0]     r_timer;
    logic              r_cap;
    logic [OUT_W-1:0]  r_cap_data;
    logic              r_core_start;
    logic              r_core_in_vld;
    logic [IN_W-1:0]   r_core_in;
    logic              r_m_valid;
    logic              r_m_err;
    logic [OUT_W-1:0]  r_m_data;
    logic [15:0]       r_infer_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [TW-1:0]     w_timer_nxt;
    logic              w_tmo;
    logic              w_res_ok;
    logic [OUT_W-1:0]  w_res_data;

    // FIFO status and handshakes; the stream is held off until the first
    // edge after reset release.
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign s_ready     = r_live & ~w_full;
    assign w_push      = s_valid & s_ready;
    assign w_pop       = (r_state == ST_IDLE) & ~w_empty & core_idle;

    // Timer compare: the cycle that would bring the timer to TIMEOUT aborts.
    assign w_timer_nxt = r_timer + TW'(1);
    assign w_tmo       = (w_timer_nxt == TW'(TIMEOUT));

    // Result selection: an out_vld on the done edge wins over an earlier capture.
    assign w_res_ok    = core_out_vld | r_cap;
    assign w_res_data  = core_out_vld ? core_out : r_cap_data;

    assign core_start  = r_core_start;
    assign core_in_vld = r_core_in_vld;
    assign core_in     = r_core_in;
    assign m_valid     = r_m_valid;
    assign m_err       = r_m_err;
    assign m_data      = r_m_data;
    assign infer_count = r_infer_count;
    assign busy        = (r_state != ST_IDLE) | ~w_empty;

    // Reset release flag: internal reset is released on the first clock edge.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count alone.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sequencer: issue one vector, wait for done or timeout, hold the result.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_cap         <= 1'b0;
            r_cap_data    <= '0;
            r_core_start  <= 1'b0;
            r_core_in_vld <= 1'b0;
            r_core_in     <= '0;
            r_m_valid     <= 1'b0;
            r_m_err       <= 1'b0;
            r_m_data      <= '0;
            r_infer_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_core_in     <= r_mem[r_rd_ptr];
                        r_core_start  <= 1'b1;
                        r_core_in_vld <= 1'b1;
                        r_timer       <= '0;
                        r_cap         <= 1'b0;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= w_timer_nxt;
                    if (core_out_vld) begin
                        r_cap      <= 1'b1;
                        r_cap_data <= core_out;
                    end
                    if (core_ready && core_done) begin
                        // Zero-latency core: done arrives with ready.
                        r_core_start  <= 1'b0;
                        r_core_in_vld <= 1'b0;
                        r_m_valid     <= 1'b1;
                        r_m_err       <= ~w_res_ok;
                        r_m_data      <= w_res_ok ? w_res_data : '0;
                        r_state       <= ST_HOLD;
                    end else if (w_tmo) begin
                        r_core_start  <= 1'b0;
                        r_core_in_vld <= 1'b0;
                        r_m_valid     <= 1'b1;
                        r_m_err       <= 1'b1;
                        r_m_data      <= '0;
                        r_state       <= ST_HOLD;
                    end else if (core_ready) begin
                        r_core_start  <= 1'b0;
                        r_core_in_vld <= 1'b0;
                        r_state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_timer <= w_timer_nxt;
                    if (core_out_vld) begin
                        r_cap      <= 1'b1;
                        r_cap_data <= core_out;
                    end
                    if (core_done) begin
                        r_m_valid <= 1'b1;
                        r_m_err   <= ~w_res_ok;
                        r_m_data  <= w_res_ok ? w_res_data : '0;
                        r_state   <= ST_HOLD;
                    end else if (w_tmo) begin
                        r_m_valid <= 1'b1;
                        r_m_err   <= 1'b1;
                        r_m_data  <= '0;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (!r_m_err) begin
                            r_infer_count <= r_infer_count + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
